instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 151 +++++++++++++++
 tb/tb_instr_encoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/memory bus of the instruction encoder: encode requests in, instruction-memory writes out.
// master = requester/memory side, slave = encoder.
`default_nettype none

interface instr_encoder_if;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [1:0]  immSrc;
  logic [31:0] opFields;
  logic [31:0] imm;
  logic        memWe;
  logic        memGnt;
  logic [31:0] memAddr;
  logic [31:0] memWd;
  logic        full;
  logic        errImm;

  modport master (
    output flush, inValid, immSrc, opFields, imm, memGnt,
    input  inReady, memWe, memAddr, memWd, full, errImm
  );

  modport slave (
    input  flush, inValid, immSrc, opFields, imm, memGnt,
    output inReady, memWe, memAddr, memWd, full, errImm
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Merges a sign-extended immediate into an RV32 I/S/B/J word and
//            writes successive words to instruction memory from BASE_ADDR.
//            Optional macro IMM_RANGE_CHECK_EN rejects unrepresentable
//            immediates with a one-cycle errImm pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  wire logic       clk,
  input  wire logic       resetN,
  instr_encoder_if.slave  bus
);

  localparam int                 c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_addr;
  logic [c_CNT_W-1:0]   r_count;
  logic [31:0]          r_wd;
  logic                 r_errImm;
  logic [31:0]          w_word;
  logic                 w_immBad;
  logic                 w_inReady;
  logic                 w_accept;
  logic                 w_grant;

  // Immediate field placement; every other bit comes straight from opFields.
  always_comb begin
    w_word = bus.opFields;
    case (bus.immSrc)
      2'b00: w_word[31:20] = bus.imm[11:0];
      2'b01: begin
        w_word[31:25] = bus.imm[11:5];
        w_word[11:7]  = bus.imm[4:0];
      end
      2'b10: begin
        w_word[31]    = bus.imm[12];
        w_word[30:25] = bus.imm[10:5];
        w_word[11:8]  = bus.imm[4:1];
        w_word[7]     = bus.imm[11];
      end
      default: begin
        w_word[31]    = bus.imm[20];
        w_word[30:21] = bus.imm[10:1];
        w_word[20]    = bus.imm[11];
        w_word[19:12] = bus.imm[19:12];
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = $signed(bus.imm);

  always_comb begin
    w_immBad = 1'b0;
    case (bus.immSrc)
      2'b00, 2'b01: w_immBad = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      2'b10:        w_immBad = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || bus.imm[0];
      default:      w_immBad = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || bus.imm[0];
    endcase
  end
`else
  logic w_unused_imm;
  assign w_unused_imm = ^bus.imm[31:21];
  assign w_immBad     = 1'b0;
`endif

  assign w_accept = w_inReady && bus.inValid;
  assign w_grant  = (r_state == S_WRITE) && bus.memGnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_inReady = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_inReady = !bus.flush;
        if (w_accept && !w_immBad) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.memGnt) begin
          w_next = (r_count == c_LAST) ? S_FULL : S_IDLE;
        end
      end
      S_FULL:  w_next = S_FULL;
      default: w_next = S_IDLE;
    endcase
    // Flush wins over any grant or request seen in the same cycle.
    if (bus.flush) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_addr   <= BASE_ADDR;
      r_count  <= '0;
      r_wd     <= '0;
      r_errImm <= 1'b0;
    end else begin
      r_errImm <= 1'b0;
      if (bus.flush) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
      end else if (w_accept) begin
        if (w_immBad) begin
          r_errImm <= 1'b1;
        end else begin
          r_wd <= w_word;
        end
      end else if (w_grant) begin
        r_addr  <= r_addr + 32'd4;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.inReady = w_inReady;
  assign bus.memWe   = (r_state == S_WRITE);
  assign bus.full    = (r_state == S_FULL);
  assign bus.memAddr = r_addr;
  assign bus.memWd   = r_wd;
  assign bus.errImm  = r_errImm;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected writes, a negedge monitor checks them.
`default_nettype none

module tb_instr_encoder;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  typedef struct { logic [31:0] addr; logic [31:0] word; } wr_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          err_cyc = -10;
  int          m_count = 0;
  logic [31:0] m_addr = BASE;
  int          gnt_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding by field extraction and shifting.
  function automatic logic [31:0] model_word(input logic [1:0] src, input logic [31:0] op, input logic [31:0] im);
    case (src)
      2'd0: return (op & 32'h000F_FFFF) | ((im & 32'hFFF) << 20);
      2'd1: return (op & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      2'd2: return (op & 32'h01FF_F07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                 | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      default: return (op & 32'h0000_0FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                 | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12);
    endcase
  endfunction

  function automatic bit model_bad(input logic [1:0] src, input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = $signed(im);
    case (src)
      2'd0, 2'd1: return (s < -2048) || (s > 2047);
      2'd2:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
      default:    return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
    endcase
`else
    return (src == 2'd3) && (im == 32'h1) && 1'b0;
`endif
  endfunction

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!resetN) begin
      exp_q.delete();
      m_addr  = BASE;
      m_count = 0;
    end
    chk("full", {31'd0, bus.full}, {31'd0, m_count == DEPTH});
    if (bus.errImm || err_cyc == cyc)
      chk("errImm", {31'd0, bus.errImm}, {31'd0, err_cyc == cyc});
    if (resetN && bus.memWe) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.memAddr, 32'hXXXX_XXXX);
      end else begin
        chk("memAddr", bus.memAddr, exp_q[0].addr);
        chk("memWd", bus.memWd, exp_q[0].word);
        if (bus.memGnt && !bus.flush) begin
          void'(exp_q.pop_front());
          m_addr  = m_addr + 32'd4;
          m_count = m_count + 1;
        end
      end
    end
    if (bus.flush) begin
      exp_q.delete();
      m_addr  = BASE;
      m_count = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (gnt_mode)
      0:       bus.memGnt = 1'b0;
      1:       bus.memGnt = 1'b1;
      default: bus.memGnt = 1'($urandom % 2);
    endcase
  end

  task automatic send(input logic [1:0] src, input logic [31:0] op, input logic [31:0] im,
                      input bit use_c, input logic [31:0] cw);
    bit got;
    bit bad;
    logic [31:0] a0;
    @(posedge clk); #1;
    bus.inValid = 1'b1; bus.immSrc = src; bus.opFields = op; bus.imm = im;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.inReady) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.inValid = 1'b0;
      return;
    end
    bad = model_bad(src, im);
    a0  = m_addr;
    if (bad) err_cyc = cyc + 1;
    else exp_q.push_back('{addr: m_addr, word: use_c ? cw : model_word(src, op, im)});
    @(posedge clk); #1;
    bus.inValid = 1'b0; bus.opFields = $urandom; bus.imm = $urandom;
    @(negedge clk);
    chk("memWe_latency", {31'd0, bus.memWe}, {31'd0, !bad});
    if (bad) chk("addr_hold", bus.memAddr, a0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic do_flush();
    @(posedge clk); #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
  endtask

  task automatic send_rand();
    logic [1:0]  src;
    logic [31:0] im;
    src = 2'($urandom % 4);
    if ($urandom % 8 == 0) im = $urandom;
    else if (src < 2) im = 32'($signed($urandom_range(0, 4095)) - 2048);
    else if (src == 2) im = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
    else im = 32'(($signed($urandom_range(0, 1048575)) - 524288) * 2);
    send(src, $urandom, im, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.inValid = 1'b0; bus.immSrc = 2'd0;
    bus.opFields = 32'd0; bus.imm = 32'd0; bus.memGnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memWe", {31'd0, bus.memWe}, 32'd0);
    chk("rst_memAddr", bus.memAddr, BASE);
    chk("rst_memWd", bus.memWd, 32'd0);
    chk("rst_errImm", {31'd0, bus.errImm}, 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    chk("rst_inReady", {31'd0, bus.inReady}, 32'd1);

    gnt_mode = 1;
    send(2'b00, 32'h0004A303, 32'hFFFF_FFFC, 1'b1, 32'hFFC4A303);
    drain();
    do_flush();
    send(2'b01, 32'h0064A023, 32'd8, 1'b1, 32'h0064A423);
    send(2'b10, 32'h00000063, 32'd8, 1'b1, 32'h00000463);
    send(2'b11, 32'h0000006F, 32'hFFFF_FFF8, 1'b1, 32'hFF9FF06F);
    drain();

    // Backpressure, then fill to DEPTH
    do_flush();
    gnt_mode = 0;
    send_rand();
    repeat (3) begin
      @(negedge clk);
      if (exp_q.size() != 0) chk("bp_memWe", {31'd0, bus.memWe}, 32'd1);
    end
    gnt_mode = 1;
    drain();
    while (m_count < DEPTH) begin
      send(2'b00, $urandom, 32'd5, 1'b0, 32'd0);
      drain();
    end
    @(negedge clk);
    chk("full_flag", {31'd0, bus.full}, 32'd1);
    chk("full_inReady", {31'd0, bus.inReady}, 32'd0);
    @(posedge clk); #1; bus.inValid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_blocks", {31'd0, bus.inReady}, 32'd0);
    bus.inValid = 1'b0;
    do_flush();
    @(negedge clk);
    chk("flush_addr", bus.memAddr, BASE);
    chk("flush_full", {31'd0, bus.full}, 32'd0);

    // Immediate just outside the I range
    send(2'b00, 32'h00000013, 32'd2048, 1'b0, 32'd0);
    drain();

    // Reset while a write is pending
    do_flush();
    gnt_mode = 0;
    send(2'b01, 32'h00000023, 32'd4, 1'b0, 32'd0);
    @(posedge clk); #1; resetN = 1'b0;
    #1;
    chk("rstw_memWe", {31'd0, bus.memWe}, 32'd0);
    chk("rstw_memAddr", bus.memAddr, BASE);
    repeat (2) @(posedge clk);
    #1; resetN = 1'b1;
    gnt_mode = 1;
    send(2'b00, 32'h00000093, 32'd1, 1'b1, 32'h00100093);
    drain();

    // Randomised traffic with occasional flushes
    gnt_mode = 2;
    for (int n = 0; n < 40; n++) begin
      drain();
      if (m_count == DEPTH) do_flush();
      send_rand();
      if ($urandom % 6 == 0) do_flush();
    end
    drain();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
